sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter_if.sv | 32 +++
 rtl/sdram_port_arbiter.sv | 111 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Client/controller bundle for the two-port SDRAM arbiter.
// The slave modport is the arbiter's view; the master modport drives clients and controller.
interface sdram_port_arbiter_if;
  logic [1:0]  ireq;
  logic [1:0]  iwe;
  logic [43:0] iaddr;
  logic [31:0] iwdata;
  logic [1:0]  oack;
  logic [15:0] ordata;
  logic [1:0]  ogrant;
  logic        oerr;
  logic        owrite_req;
  logic [21:0] owrite_address;
  logic [15:0] owrite_data;
  logic        iwrite_ack;
  logic        oread_req;
  logic [21:0] oread_address;
  logic [15:0] iread_data;
  logic        iread_ack;

  modport slave (
    input  ireq, iwe, iaddr, iwdata, iwrite_ack, iread_data, iread_ack,
    output oack, ordata, ogrant, oerr, owrite_req, owrite_address, owrite_data,
           oread_req, oread_address
  );

  modport master (
    output ireq, iwe, iaddr, iwdata, iwrite_ack, iread_data, iread_ack,
    input  oack, ordata, ogrant, oerr, owrite_req, owrite_address, owrite_data,
           oread_req, oread_address
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter in front of a single SDRAM controller (IDLE/ISSUE/RELEASE).
// Optional ISSUE-state timeout abort is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  iclk,
  input  logic                  ireset,
  sdram_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        last;
  logic        cli;
  logic        we;
  logic        pick;
  logic        pick_we;
  logic [21:0] pick_addr;
  logic [15:0] pick_data;
  logic        ack_hit;
  logic        tmo_hit;

  // Contention goes to the client not served last; a lone requester always wins.
  assign pick      = (bus.ireq == 2'b11) ? ~last : bus.ireq[1];
  assign pick_we   = bus.iwe[pick];
  assign pick_addr = pick ? bus.iaddr[43:22] : bus.iaddr[21:0];
  assign pick_data = pick ? bus.iwdata[31:16] : bus.iwdata[15:0];
  assign ack_hit   = we ? bus.iwrite_ack : bus.iread_ack;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus.oerr = err_q;
`else
  assign tmo_hit  = 1'b0;
  assign bus.oerr = 1'b0;
`endif

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state              <= IDLE;
      last               <= 1'b1;
      cli                <= 1'b0;
      we                 <= 1'b0;
      bus.ogrant         <= 2'b00;
      bus.oack           <= 2'b00;
      bus.owrite_req     <= 1'b0;
      bus.oread_req      <= 1'b0;
      bus.owrite_address <= '0;
      bus.owrite_data    <= '0;
      bus.oread_address  <= '0;
      bus.ordata         <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      tmo_cnt            <= '0;
      err_q              <= 1'b0;
`endif
    end else begin
      bus.oack <= 2'b00;
`ifdef SDRAM_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.ireq) begin
            state      <= ISSUE;
            cli        <= pick;
            last       <= pick;
            we         <= pick_we;
            bus.ogrant <= pick ? 2'b10 : 2'b01;
            if (pick_we) begin
              bus.owrite_req     <= 1'b1;
              bus.owrite_address <= pick_addr;
              bus.owrite_data    <= pick_data;
            end else begin
              bus.oread_req      <= 1'b1;
              bus.oread_address  <= pick_addr;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ISSUE: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
          // A matching ack in the timeout cycle wins, so the error flag stays low.
          if (ack_hit || tmo_hit) begin
            state          <= RELEASE;
            bus.owrite_req <= 1'b0;
            bus.oread_req  <= 1'b0;
            bus.ogrant     <= 2'b00;
            bus.oack       <= cli ? 2'b10 : 2'b01;
            if (!we && ack_hit) bus.ordata <= bus.iread_data;
`ifdef SDRAM_ARB_TIMEOUT_EN
            err_q <= !ack_hit;
`endif
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter; covers SDRAM_ARB_TIMEOUT_EN on or off.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_rd = '0;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .iclk   (clk),
    .ireset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, bus.ogrant, 0);
    check({tag, "_ack"}, bus.oack, 0);
    check({tag, "_err"}, bus.oerr, 0);
    check({tag, "_reqs"}, {bus.owrite_req, bus.oread_req}, 0);
    check({tag, "_waddr"}, bus.owrite_address, 0);
    check({tag, "_wdata"}, bus.owrite_data, 0);
    check({tag, "_raddr"}, bus.oread_address, 0);
    check({tag, "_rdata"}, bus.ordata, 0);
  endtask

  // Completion monitor: every oack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("req_excl", bus.owrite_req & bus.oread_req, 0);
      check("grant_1hot", $onehot0(bus.ogrant), 1);
      if (bus.oack != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexp_ack", bus.oack, 0);
        end else begin
          mon_e = sb.pop_front();
          check("ack", bus.oack, mon_e.ack);
          check("ack_err", bus.oerr, mon_e.err);
          check("ack_rdata", bus.ordata, mon_e.rdata);
        end
      end else begin
        check("err_idle", bus.oerr, 0);
      end
    end
  end

  task automatic run_txn(input int c, input bit w, input logic [21:0] a, input logic [15:0] wd,
                         input logic [15:0] rd, input int dly, input bit fault);
    bus.ireq[c] = 1'b1;
    bus.iwe[c]  = w;
    if (c == 0) begin
      bus.iaddr[21:0]  = a;
      bus.iwdata[15:0] = wd;
    end else begin
      bus.iaddr[43:22]  = a;
      bus.iwdata[31:16] = wd;
    end
    tick();
    bus.ireq[c] = 1'b0;
    bus.iwe[c]  = ~w;
    bus.iaddr   = {$urandom, $urandom};
    bus.iwdata  = $urandom;
    check("grant", bus.ogrant, (c == 0) ? 1 : 2);
    check("wreq", bus.owrite_req, w);
    check("rreq", bus.oread_req, !w);
    for (int i = 0; i < dly; i++) begin
      if (fault && i == 0) begin
        if (w) bus.iread_ack = 1'b1;
        else   bus.iwrite_ack = 1'b1;
      end
      tick();
      bus.iread_ack  = 1'b0;
      bus.iwrite_ack = 1'b0;
    end
    check("hold_req", w ? bus.owrite_req : bus.oread_req, 1);
    check("hold_grant", bus.ogrant, (c == 0) ? 1 : 2);
    if (w) begin
      check("waddr", bus.owrite_address, a);
      check("wdata", bus.owrite_data, wd);
    end else begin
      check("raddr", bus.oread_address, a);
    end
    if (!w) model_rd = rd;
    sb.push_back('{ack: (c == 0) ? 2'b01 : 2'b10, err: 1'b0, rdata: model_rd});
    if (w) begin
      bus.iwrite_ack = 1'b1;
    end else begin
      bus.iread_ack  = 1'b1;
      bus.iread_data = rd;
    end
    tick();
    bus.iwrite_ack = 1'b0;
    bus.iread_ack  = 1'b0;
    bus.iread_data = $urandom;
    check("req_drop", {bus.owrite_req, bus.oread_req}, 0);
    check("grant_clr", bus.ogrant, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.ireq = '0; bus.iwe = '0; bus.iaddr = '0; bus.iwdata = '0;
    bus.iwrite_ack = 1'b0; bus.iread_ack = 1'b0; bus.iread_data = '0;
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("rst");
    rst = 1'b0;
    tick();

    run_txn(0, 1'b1, 22'h0, 16'd19, 16'h0, 4, 1'b0);
    run_txn(1, 1'b0, 22'h3FFFFF, 16'h0, 16'hBEEF, 2, 1'b0);
    run_txn(0, 1'b1, 22'h12345, 16'hA5A5, 16'h0, 3, 1'b1);
    run_txn(0, 1'b0, 22'h00ABC, 16'h0, 16'h1234, 0, 1'b0);
    run_txn(1, 1'b0, 22'h2AAAA, 16'h0, 16'h5A5A, 3, 1'b1);

    // Acks while idle must be ignored.
    bus.iwrite_ack = 1'b1;
    bus.iread_ack  = 1'b1;
    tick();
    bus.iwrite_ack = 1'b0;
    bus.iread_ack  = 1'b0;
    tick();
    check("idle_grant", bus.ogrant, 0);
    check("idle_reqs", {bus.owrite_req, bus.oread_req}, 0);

    // Reset in the middle of ISSUE abandons the transaction.
    bus.ireq = 2'b01; bus.iwe = 2'b00; bus.iaddr[21:0] = 22'h777;
    tick();
    bus.ireq = 2'b00;
    check("mid_rreq", bus.oread_req, 1);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    model_rd = '0;
    bus.ireq = 2'b11; bus.iwe = 2'b11;
    bus.iaddr = {22'h2, 22'h1}; bus.iwdata = {16'hB0B0, 16'hA0A0};
    tick();
    rst = 1'b0;

    // Both clients hold ireq from reset: grants alternate starting at client 0.
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!bus.owrite_req && n < 10) begin
        tick();
        n++;
      end
      if (k > 0) check("spacing", n, 2);
      check("rr_grant", bus.ogrant, (k % 2 == 0) ? 1 : 2);
      check("rr_wdata", bus.owrite_data, (k % 2 == 0) ? 16'hA0A0 : 16'hB0B0);
      sb.push_back('{ack: (k % 2 == 0) ? 2'b01 : 2'b10, err: 1'b0, rdata: model_rd});
      bus.iwrite_ack = 1'b1;
      tick();
      bus.iwrite_ack = 1'b0;
      check("rr_rel_grant", bus.ogrant, 0);
      check("rr_rel_reqs", {bus.owrite_req, bus.oread_req}, 0);
    end
    bus.ireq = 2'b00;
    tick();
    tick();

    bus.ireq = 2'b10; bus.iwe = 2'b10;
    bus.iaddr[43:22] = 22'h155; bus.iwdata[31:16] = 16'hC0DE;
    tick();
    bus.ireq = 2'b00;
`ifdef SDRAM_ARB_TIMEOUT_EN
    sb.push_back('{ack: 2'b10, err: 1'b1, rdata: model_rd});
    n = 0;
    while (bus.owrite_req && n < 20) begin
      n++;
      tick();
    end
    check("tmo_len", n, 8);
`else
    n = 0;
    while (bus.owrite_req && n < 40) begin
      n++;
      tick();
    end
    check("no_tmo_hold", n, 40);
    sb.push_back('{ack: 2'b10, err: 1'b0, rdata: model_rd});
    bus.iwrite_ack = 1'b1;
    tick();
    bus.iwrite_ack = 1'b0;
`endif
    check("tmo_reqs", {bus.owrite_req, bus.oread_req}, 0);
    tick();
    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
